tbre_sweep_scheduler: RTL
=========================

Name: tbre_sweep_scheduler

Overview:
- Queues revocation-sweep region requests written over the register bus.
- Sequences them one at a time into the TBRE engine: drives start/end address, pulses go, then tracks the engine busy status to completion.
- Sits between the CPU register bus and the core-side TBRE interface.
- Replaces single-shot software polling with a hardware work queue, an epoch counter and interrupts.

Parameters:
- FIFO_DEPTH, 4, number of queued region descriptors; power of two, 2..16.
- START_TIMEOUT, 64, cycles to wait for busy to rise after go before declaring a timeout.
- EPOCH_W, 16, width of the completed-sweep counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- reg_en_i  in  1  register access strobe
- reg_addr_i  in  32  byte address; [7:2] decoded
- reg_wdata_i  in  32  write data
- reg_we_i  in  1  1 = write, 0 = read
- reg_rdata_o  out  32  read data, registered
- reg_ready_o  out  1  tied 1
- tbre_busy_i  in  1  engine busy status from core
- tbre_start_addr_o  out  32  active region start
- tbre_end_addr_o  out  32  active region end
- tbre_go_o  out  1  one-cycle start pulse
- intr_o  out  1  level interrupt

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; epoch 0; CTRL 0; INTR_STAT 0.
- Register map (addr[7:2]). Reads return data on the cycle after rd_op. Unmapped addresses read 0; writes to them are ignored.
  - 0x0 STAGE_START: RW.
  - 0x1 STAGE_END: RW.
  - 0x2 PUSH: a write pushes {STAGE_START, STAGE_END}. Reads return {16'h5C00, 12'h0, fifo_count[3:0]}.
  - 0x3 STATUS: RO, {epoch zero-extended/truncated to 16, 8'h0, 2'h0, state[1:0], 3'h0, busy_i}.
  - 0x4 CTRL: RW. bit0 enable, bit1 done_ie, bit2 err_ie. Bit3 flush is write-1, self-clearing, and reads 0.
  - 0x5 INTR_STAT: bit0 done, bit1 overflow, bit2 timeout, bit3 badrange. Write-1-to-clear.
- Push rules:
  - end <= start: rejected; sets badrange.
  - FIFO full: dropped; sets overflow.
  - Push and pop in the same cycle: count unchanged; the pop data is the oldest entry.
- Flush empties the FIFO the next cycle. It does not abort an in-flight sweep. Flush wins over a simultaneous push.
- State machine, encoded IDLE=0, ISSUE=1, WAIT_START=2, WAIT_DONE=3:
  - IDLE: if enable and FIFO not empty, pop and load the start/end outputs (they hold until the next pop), then go to ISSUE.
  - ISSUE: tbre_go_o=1 for exactly one cycle; clear timer; go to WAIT_START.
  - WAIT_START: if busy_i=1, go to WAIT_DONE. Otherwise increment the timer (see Optional Feature).
  - WAIT_DONE: when busy_i=0, increment epoch (wraps mod 2^EPOCH_W). If the FIFO is empty at that cycle, set done. Go to IDLE.
- Clearing enable mid-sweep: the current sweep completes; no further pops.
- Minimum issue-to-issue spacing is 4 cycles. go never fires while the FSM is not in ISSUE.
- Interrupt and error sets:
  - intr_o = (done & done_ie) | ((overflow | timeout | badrange) & err_ie).
  - A hardware set and a W1C of the same bit in the same cycle: the set wins.
- Reset mid-operation: everything returns to reset values immediately; go deasserts asynchronously.

Optional Feature:
- Macro TBRE_SCHED_TIMEOUT_EN.
- Defined: in WAIT_START, when the timer reaches START_TIMEOUT-1 with busy_i still 0, set timeout, drop the region (no epoch increment) and return to IDLE.
- Undefined: WAIT_START waits indefinitely; the timeout bit is constant 0; no timer logic is instantiated.

Test Plan:
1. Write START=0x2000_0000, END=0x2000_1000, PUSH; CTRL=0x3; model busy rising 2 cycles after go and falling 10 cycles later -> addr outputs load those values, single go pulse, epoch=1, done=1, intr_o=1; W1C 0x1 clears intr_o.
2. Push 5 valid regions with enable=0 (FIFO_DEPTH=4) -> fifo_count=4, overflow=1; set enable -> exactly 4 go pulses in FIFO order, epoch=4, done set only after the 4th completion.
3. Push START=0x100, END=0x100 -> rejected, fifo_count=0, badrange=1; intr_o=1 only with err_ie=1.
4. With TBRE_SCHED_TIMEOUT_EN, hold busy_i=0 after go -> timeout=1 exactly 64 cycles after go, state IDLE, epoch unchanged, next queued region issued. Without the macro -> FSM stays in WAIT_START, timeout reads 0.
5. During WAIT_DONE with 2 queued entries, write CTRL flush -> fifo_count=0 next cycle; the in-flight sweep completes, epoch+1, done=1, no further go.
6. Assert rst_i while in WAIT_DONE with tbre_go_o high in a prior cycle -> all outputs 0, STATUS reads 0x0000_000X (busy only), fifo_count=0.

Source files
------------

// File: rtl/tbre_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tbre_sweep_scheduler
//
// Hardware work queue for revocation sweeps. Software stages a region
// (start/end) over the register bus and pushes it into a small FIFO. The
// scheduler pops one region at a time, presents it to the TBRE engine, pulses
// go, and follows the engine busy status until the sweep finishes. Completed
// sweeps advance an epoch counter. Completion and error events raise sticky
// interrupt status bits.
//
// Optional feature: define TBRE_SCHED_TIMEOUT_EN to abandon a region when the
// engine fails to raise busy within START_TIMEOUT cycles of go. Without the
// macro, the scheduler waits for busy indefinitely and the timeout status bit
// is constant 0.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   reg_en_i, reg_we_i      register access strobe and direction (1 = write)
//   reg_addr_i              byte address, bits [7:2] select the register
//   reg_wdata_i             write data
//   reg_rdata_o             read data, valid the cycle after the read
//   reg_ready_o             always 1
//   tbre_busy_i             engine busy status
//   tbre_start_addr_o       start address of the active region
//   tbre_end_addr_o         end address of the active region
//   tbre_go_o               one-cycle start pulse to the engine
//   intr_o                  level interrupt
// -----------------------------------------------------------------------------
module tbre_sweep_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 64,
  parameter int EPOCH_W       = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_en_i,
  input  logic [31:0] reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_we_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_ready_o,
  input  logic        tbre_busy_i,
  output logic [31:0] tbre_start_addr_o,
  output logic [31:0] tbre_end_addr_o,
  output logic        tbre_go_o,
  output logic        intr_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [5:0] A_STAGE_START = 6'h00;
  localparam logic [5:0] A_STAGE_END   = 6'h01;
  localparam logic [5:0] A_PUSH        = 6'h02;
  localparam logic [5:0] A_STATUS      = 6'h03;
  localparam logic [5:0] A_CTRL        = 6'h04;
  localparam logic [5:0] A_INTR_STAT   = 6'h05;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_START = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        stage_start_q, stage_start_d;
  logic [31:0]        stage_end_q, stage_end_d;
  logic [2:0]         ctrl_q, ctrl_d;          // {err_ie, done_ie, enable}
  logic [3:0]         stat_q, stat_d;          // {badrange, timeout, overflow, done}
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]        start_addr_q, start_addr_d;
  logic [31:0]        end_addr_q, end_addr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [63:0]        fifo_mem [FIFO_DEPTH];   // {start, end}

  logic [5:0] addr;
  logic       wr_en, rd_en;
  logic       push_req, push_ok, flush, range_bad;
  logic       fifo_empty, fifo_full;
  logic       pop, sweep_done, timeout_hit;
  logic [3:0] stat_set, stat_clr;
  logic       unused_ok;

  assign addr        = reg_addr_i[7:2];
  assign wr_en       = reg_en_i & reg_we_i;
  assign rd_en       = reg_en_i & ~reg_we_i;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_C);
  assign range_bad   = (stage_end_q <= stage_start_q);
  assign push_req    = wr_en && (addr == A_PUSH);
  assign flush       = wr_en && (addr == A_CTRL) && reg_wdata_i[3];
  // Flush takes priority over any enqueue in the same cycle.
  assign push_ok     = push_req & ~range_bad & ~fifo_full & ~flush;
  assign unused_ok   = ^{reg_addr_i[31:8], reg_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Start timeout (optional)
  // ---------------------------------------------------------------------------
`ifdef TBRE_SCHED_TIMEOUT_EN
  localparam int TW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d     = timer_q;
    timeout_hit = 1'b0;
    if (state_q == S_ISSUE) begin
      timer_d = '0;
    end else if ((state_q == S_WAIT_START) && !tbre_busy_i) begin
      if (timer_q == TIMER_LAST) timeout_hit = 1'b1;
      else                       timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  logic unused_cfg;
  assign timeout_hit = 1'b0;
  assign unused_cfg  = ^(32'(START_TIMEOUT));
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (pop) state_d = S_ISSUE;
      S_ISSUE:      state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (tbre_busy_i)      state_d = S_WAIT_DONE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WAIT_DONE:  if (!tbre_busy_i) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Sequencer FSM: outputs. go comes straight from the state register, so an
  // asynchronous reset drops it immediately.
  always_comb begin
    tbre_go_o  = 1'b0;
    pop        = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      S_IDLE:      pop        = ctrl_q[0] & ~fifo_empty & ~flush;
      S_ISSUE:     tbre_go_o  = 1'b1;
      S_WAIT_DONE: sweep_done = ~tbre_busy_i;
      default:     ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file, FIFO control, epoch and status
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_start_d = stage_start_q;
    stage_end_d   = stage_end_q;
    ctrl_d        = ctrl_q;
    if (wr_en && (addr == A_STAGE_START)) stage_start_d = reg_wdata_i;
    if (wr_en && (addr == A_STAGE_END))   stage_end_d   = reg_wdata_i;
    if (wr_en && (addr == A_CTRL))        ctrl_d        = reg_wdata_i[2:0];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end

    // Region outputs hold the last popped descriptor until the next pop.
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    if (pop) begin
      start_addr_d = fifo_mem[rd_ptr_q][63:32];
      end_addr_d   = fifo_mem[rd_ptr_q][31:0];
    end

    epoch_d = epoch_q + EPOCH_W'(sweep_done);

    // Hardware sets are ORed in after the W1C so a same-cycle set survives.
    stat_set = {push_req & range_bad,
                timeout_hit,
                push_req & ~range_bad & fifo_full & ~flush,
                sweep_done & fifo_empty};
    stat_clr = (wr_en && (addr == A_INTR_STAT)) ? reg_wdata_i[3:0] : 4'h0;
    stat_d   = (stat_q & ~stat_clr) | stat_set;
  end

  // Registered read data; holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        A_STAGE_START: rdata_d = stage_start_q;
        A_STAGE_END:   rdata_d = stage_end_q;
        A_PUSH:        rdata_d = {16'h5C00, 12'h000, 4'(count_q)};
        A_STATUS:      rdata_d = {16'(epoch_q), 8'h00, 2'b00, state_q, 3'b000, tbre_busy_i};
        A_CTRL:        rdata_d = {29'h0, ctrl_q};
        A_INTR_STAT:   rdata_d = {28'h0, stat_q};
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_start_q <= '0;
      stage_end_q   <= '0;
      ctrl_q        <= '0;
      stat_q        <= '0;
      epoch_q       <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      start_addr_q  <= '0;
      end_addr_q    <= '0;
      rdata_q       <= '0;
    end else begin
      stage_start_q <= stage_start_d;
      stage_end_q   <= stage_end_d;
      ctrl_q        <= ctrl_d;
      stat_q        <= stat_d;
      epoch_q       <= epoch_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      start_addr_q  <= start_addr_d;
      end_addr_q    <= end_addr_d;
      rdata_q       <= rdata_d;
    end
  end

  // Descriptor storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {stage_start_q, stage_end_q};
  end

  assign reg_rdata_o       = rdata_q;
  assign reg_ready_o       = 1'b1;
  assign tbre_start_addr_o = start_addr_q;
  assign tbre_end_addr_o   = end_addr_q;
  assign intr_o            = (stat_q[0] & ctrl_q[1]) | ((|stat_q[3:1]) & ctrl_q[2]);

endmodule
